// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and defaults for the data-memory access controller and its
// timeout counter.
package dmem_access_ctrl_pkg;

   localparam int TIMEOUT_DEF = 15;
   localparam int AW_DEF      = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE,
      ST_HALT
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   function automatic op_e decode_op(input logic is_write);
      return is_write ? OP_WR : OP_RD;
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Memory-side bus between the access controller (master) and the data memory
// (slave): request strobe, address/data, busy/done handshake and dump strobe.
interface dmem_access_ctrl_if
   import dmem_access_ctrl_pkg::*;
#(
   parameter int AW = AW_DEF
) ();

   logic          mem_en;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [AW-1:0] mem_wdata;
   logic          mem_busy;
   logic          mem_done;
   logic [AW-1:0] mem_rdata;
   logic          mem_dump;

   modport master (
      output mem_en,
      output mem_wr,
      output mem_addr,
      output mem_wdata,
      output mem_dump,
      input  mem_busy,
      input  mem_done,
      input  mem_rdata
   );

   modport slave (
      input  mem_en,
      input  mem_wr,
      input  mem_addr,
      input  mem_wdata,
      input  mem_dump,
      output mem_busy,
      output mem_done,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_timeout_cnt.sv
// Saturating wait-cycle counter; tc flags that TIMEOUT cycles have elapsed
// since the last clear.
module dmem_timeout_cnt
   import dmem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int            CW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   logic [CW-1:0] count;

   // Holds at TMAX instead of wrapping so a stuck memory keeps tc asserted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != TMAX)) begin
         count <= count + CW'(1);
      end
   end

   assign tc = (count == TMAX);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns decoded LD/ST/HALT requests into a
// single-outstanding memory transaction, stalling the pipeline meanwhile.
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int AW      = AW_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                memread,
   input  logic                memwrt,
   input  logic                dmp,
   input  logic [AW-1:0]       addr,
   input  logic [AW-1:0]       wdata,
   dmem_access_ctrl_if.master  bus,
   output logic                stall,
   output logic [AW-1:0]       rdata,
   output logic                rdata_valid,
   output logic                err,
   output logic                halted
);

   state_e        state_q;
   state_e        state_d;
   op_e           op_q;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] wdata_q;
   logic [AW-1:0] rdata_q;
   logic          dump_pend;
   logic          err_q;
   logic          dump_q;

   logic          req_ok;
   logic          req_bad;
   logic          dump_req;
   logic          mem_en_c;
   logic          rd_capture;
   logic          timeout;
   logic          reject;
   logic          cnt_clr;
   logic          cnt_en;
   logic          cnt_tc;

   // Exactly one of read/write and a halfword-aligned address is acceptable.
   assign req_ok   = (memread ^ memwrt) & ~addr[0];
   assign req_bad  = (memread & memwrt) | ((memread ^ memwrt) & addr[0]);
   assign dump_req = dump_pend | dmp;

   dmem_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tc    (cnt_tc)
   );

   // Next-state and combinational outputs; an access that finishes or aborts
   // while a dump is pending lands in HALT rather than IDLE.
   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      mem_en_c    = 1'b0;
      rd_capture  = 1'b0;
      timeout     = 1'b0;
      reject      = 1'b0;
      rdata_valid = 1'b0;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            reject = req_bad;
            if (req_ok) begin
               stall   = 1'b1;
               state_d = ST_REQ;
            end else if (dmp) begin
               state_d = ST_HALT;
            end
         end

         ST_REQ: begin
            stall    = 1'b1;
            mem_en_c = 1'b1;
            if (!bus.mem_busy) begin
               cnt_clr = 1'b1;
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            stall = 1'b1;
            if (bus.mem_done) begin
               rd_capture = (op_q == OP_RD);
               state_d    = ST_DONE;
            end else if (cnt_tc) begin
               timeout = 1'b1;
               state_d = dump_req ? ST_HALT : ST_IDLE;
            end else begin
               cnt_en = 1'b1;
            end
         end

         ST_DONE: begin
            rdata_valid = (op_q == OP_RD);
            state_d     = dump_req ? ST_HALT : ST_IDLE;
         end

         ST_HALT: begin
            state_d = ST_HALT;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register plus the latched request, load result and one-cycle
   // strobes (rejection error and memory dump on entry to HALT).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_RD;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         dump_pend <= 1'b0;
         err_q     <= 1'b0;
         dump_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= reject;
         dump_q  <= (state_d == ST_HALT) && (state_q != ST_HALT);

         if ((state_q == ST_IDLE) && req_ok) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_q    <= decode_op(memwrt);
         end

         if (rd_capture) begin
            rdata_q <= bus.mem_rdata;
         end

         if (dmp && (((state_q == ST_IDLE) && req_ok) ||
                     (state_q == ST_REQ) || (state_q == ST_WAIT))) begin
            dump_pend <= 1'b1;
         end else if (state_d == ST_IDLE) begin
            dump_pend <= 1'b0;
         end
      end
   end

   assign bus.mem_en    = mem_en_c;
   assign bus.mem_wr    = mem_en_c & (op_q == OP_WR);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_dump  = dump_q;

   assign rdata  = rdata_q;
   assign err    = err_q | timeout;
   assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed requests push expected bus
// and result events; a negedge monitor pops and compares them.
module tb_dmem_access_ctrl;

   localparam int AW      = 16;
   localparam int EV_REQ  = 0;
   localparam int EV_RDV  = 1;
   localparam int EV_ERR  = 2;
   localparam int EV_DUMP = 3;

   typedef struct {
      int            kind;
      logic          wr;
      logic [AW-1:0] a;
      logic [AW-1:0] d;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          memread;
   logic          memwrt;
   logic          dmp;
   logic [AW-1:0] addr;
   logic [AW-1:0] wdata;
   logic          stall;
   logic [AW-1:0] rdata;
   logic          rdata_valid;
   logic          err;
   logic          halted;

   ev_t           sb[$];
   int            nComp = 0;
   int            nMis  = 0;
   logic          monEn = 1'b0;

   int            busyLeft = 0;
   int            cfgLat   = 0;
   int            pend     = 0;
   logic          armed    = 1'b0;
   logic [AW-1:0] cfgRdata = '0;

   dmem_access_ctrl_if #(.AW(AW)) bus ();

   dmem_access_ctrl #(
      .TIMEOUT (15),
      .AW      (AW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .memread     (memread),
      .memwrt      (memwrt),
      .dmp         (dmp),
      .addr        (addr),
      .wdata       (wdata),
      .bus         (bus),
      .stall       (stall),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .err         (err),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nComp++;
      if (act !== exp) begin
         nMis++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pushEv(input int kind, input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] d);
      ev_t e;
      e.kind = kind;
      e.wr   = wr;
      e.a    = a;
      e.d    = d;
      sb.push_back(e);
   endtask

   task automatic expectEvent(input int kind, input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] d);
      ev_t e;
      if (sb.size() == 0) begin
         nComp++;
         nMis++;
         $display("[TB] FAIL unexpected_event: got kind %0d wr %0b a %0h d %0h expected none", kind, wr, a, d);
      end else begin
         e = sb.pop_front();
         checkOutput("event_kind", 64'(kind), 64'(e.kind));
         checkOutput("event_payload", 64'({wr, a, d}), 64'({e.wr, e.a, e.d}));
      end
   endtask

   function automatic logic [63:0] allOutputs();
      return 64'({stall, rdata_valid, err, halted, bus.mem_en, bus.mem_wr, bus.mem_dump,
                  rdata, bus.mem_addr, bus.mem_wdata});
   endfunction

   task automatic setMem(input int busyCycles, input int lat, input logic [AW-1:0] rd);
      busyLeft = busyCycles;
      cfgLat   = lat;
      cfgRdata = rd;
      armed    = 1'b0;
   endtask

   task automatic doReset();
      rst_n   = 1'b0;
      memread = 1'b0;
      memwrt  = 1'b0;
      dmp     = 1'b0;
      addr    = '0;
      wdata   = '0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   // Holds the request while stall is high (pipeline behaviour), then drops it.
   task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                input logic [AW-1:0] a, input logic [AW-1:0] d,
                                input int dmpCyc, input int expStall);
      int cyc;
      int stalls;
      cyc    = 0;
      stalls = 0;
      tick();
      memread = rd;
      memwrt  = wr;
      addr    = a;
      wdata   = d;
      dmp     = (dmpCyc == 0);
      forever begin
         @(negedge clk);
         if (stall) stalls++;
         if (!stall || err || cyc >= 60) break;
         tick();
         cyc++;
         if (cyc == dmpCyc) dmp = 1'b1;
      end
      tick();
      memread = 1'b0;
      memwrt  = 1'b0;
      dmp     = 1'b0;
      addr    = '0;
      wdata   = '0;
      checkOutput({name, "_stall_cycles"}, 64'(stalls), 64'(expStall));
      repeat (2) tick();
      checkOutput({name, "_drain"}, 64'(sb.size()), 64'd0);
   endtask

   // Memory model: busy for busyLeft request cycles, then done cfgLat WAIT
   // cycles after acceptance.
   initial begin
      bus.mem_busy  = 1'b0;
      bus.mem_done  = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         bus.mem_busy = 1'b0;
         bus.mem_done = 1'b0;
         if (bus.mem_en === 1'b1) begin
            if (busyLeft > 0) begin
               bus.mem_busy = 1'b1;
               busyLeft--;
            end else begin
               armed = 1'b1;
               pend  = cfgLat;
            end
         end else if (armed) begin
            if (pend == 0) begin
               bus.mem_done  = 1'b1;
               bus.mem_rdata = cfgRdata;
               armed         = 1'b0;
            end else begin
               pend--;
            end
         end
      end
   end

   // Monitor: every presented output event is matched against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (monEn) begin
            if (bus.mem_en === 1'b1) expectEvent(EV_REQ, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
            if (rdata_valid === 1'b1) expectEvent(EV_RDV, 1'b0, rdata, '0);
            if (err === 1'b1) expectEvent(EV_ERR, 1'b0, '0, '0);
            if (bus.mem_dump === 1'b1) expectEvent(EV_DUMP, 1'b0, '0, '0);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n   = 1'b0;
      memread = 1'b0;
      memwrt  = 1'b0;
      dmp     = 1'b0;
      addr    = '0;
      wdata   = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      monEn = 1'b1;
      @(negedge clk);
      checkOutput("reset_outputs", allOutputs(), 64'd0);

      $display("[TB] load, immediate done");
      setMem(0, 0, 16'hBEEF);
      pushEv(EV_REQ, 1'b0, 16'h0010, 16'h0000);
      pushEv(EV_RDV, 1'b0, 16'hBEEF, 16'h0000);
      applyStimulus("ld_basic", 1'b1, 1'b0, 16'h0010, 16'h0000, -1, 3);
      checkOutput("ld_basic_rdata", 64'(rdata), 64'hBEEF);

      $display("[TB] store with two busy cycles");
      setMem(2, 0, 16'h0000);
      repeat (3) pushEv(EV_REQ, 1'b1, 16'h0020, 16'h1234);
      applyStimulus("st_busy", 1'b0, 1'b1, 16'h0020, 16'h1234, -1, 5);

      $display("[TB] rejected requests");
      setMem(0, 0, 16'h0000);
      pushEv(EV_ERR, 1'b0, 16'h0000, 16'h0000);
      applyStimulus("ld_misaligned", 1'b1, 1'b0, 16'h0011, 16'h0000, -1, 0);
      pushEv(EV_ERR, 1'b0, 16'h0000, 16'h0000);
      applyStimulus("rd_and_wr", 1'b1, 1'b1, 16'h0040, 16'h9999, -1, 0);

      $display("[TB] load timeout");
      setMem(0, 1000, 16'h0000);
      pushEv(EV_REQ, 1'b0, 16'h0030, 16'h0000);
      pushEv(EV_ERR, 1'b0, 16'h0000, 16'h0000);
      applyStimulus("ld_timeout", 1'b1, 1'b0, 16'h0030, 16'h0000, -1, 18);
      checkOutput("ld_timeout_rdata_kept", 64'(rdata), 64'hBEEF);
      checkOutput("ld_timeout_stall_low", 64'(stall), 64'd0);

      $display("[TB] load with three wait cycles");
      setMem(0, 3, 16'hA5C3);
      pushEv(EV_REQ, 1'b0, 16'h0FFE, 16'h0000);
      pushEv(EV_RDV, 1'b0, 16'hA5C3, 16'h0000);
      applyStimulus("ld_lat3", 1'b1, 1'b0, 16'h0FFE, 16'h0000, -1, 6);

      $display("[TB] reset during wait");
      setMem(0, 5, 16'h7777);
      pushEv(EV_REQ, 1'b0, 16'h0050, 16'h0000);
      tick();
      memread = 1'b1;
      addr    = 16'h0050;
      repeat (3) tick();
      rst_n   = 1'b0;
      memread = 1'b0;
      addr    = '0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_wait_outputs", allOutputs(), 64'd0);
      repeat (6) tick();
      checkOutput("late_done_rdata", 64'(rdata), 64'd0);
      checkOutput("late_done_drain", 64'(sb.size()), 64'd0);

      $display("[TB] dump during load wait");
      setMem(0, 2, 16'h1357);
      pushEv(EV_REQ, 1'b0, 16'h0060, 16'h0000);
      pushEv(EV_RDV, 1'b0, 16'h1357, 16'h0000);
      pushEv(EV_DUMP, 1'b0, 16'h0000, 16'h0000);
      applyStimulus("ld_dmp", 1'b1, 1'b0, 16'h0060, 16'h0000, 2, 5);
      checkOutput("ld_dmp_halted", 64'(halted), 64'd1);
      checkOutput("ld_dmp_rdata", 64'(rdata), 64'h1357);
      applyStimulus("halt_ignore", 1'b1, 1'b0, 16'h0070, 16'h0000, -1, 0);
      checkOutput("halt_sticky", 64'(halted), 64'd1);

      doReset();
      @(negedge clk);
      checkOutput("halt_reset_clears", 64'(halted), 64'd0);

      $display("[TB] dump with no request");
      pushEv(EV_DUMP, 1'b0, 16'h0000, 16'h0000);
      applyStimulus("dmp_idle", 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 0);
      checkOutput("dmp_idle_halted", 64'(halted), 64'd1);

      doReset();
      $display("[TB] dump together with a store");
      setMem(0, 1, 16'h0000);
      pushEv(EV_REQ, 1'b1, 16'h0080, 16'hCAFE);
      pushEv(EV_DUMP, 1'b0, 16'h0000, 16'h0000);
      applyStimulus("st_dmp", 1'b0, 1'b1, 16'h0080, 16'hCAFE, 0, 4);
      checkOutput("st_dmp_halted", 64'(halted), 64'd1);

      repeat (3) tick();
      checkOutput("scoreboard_final", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nMis);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles to wait for mem_done before aborting an access.
REQ-002 Parameter AW, default 16: address and data width.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; synchronous and active-low.
REQ-005 memread  in  1  decoded load request (LD).
REQ-006 memwrt  in  1  decoded store request (ST, STU).
REQ-007 dmp  in  1  decoded HALT; requests a memory dump and stop.
REQ-008 addr  in  AW  effective address from the ALU.
REQ-009 wdata  in  AW  store data.
REQ-010 mem_en  out  1  memory access strobe.
REQ-011 mem_wr  out  1  1 = write, 0 = read; valid with mem_en.
REQ-012 mem_addr, mem_wdata  out  AW  latched address and data.
REQ-013 mem_busy  in  1  memory cannot accept a request this cycle.
REQ-014 mem_done  in  1  access complete; mem_rdata valid this cycle.
REQ-015 mem_rdata  in  AW  read data.
REQ-016 mem_dump  out  1  one-cycle dump strobe to memory.
REQ-017 stall  out  1  pipeline must hold the current instruction.
REQ-018 rdata  out  AW  registered load result.
REQ-019 rdata_valid  out  1  rdata valid; one-cycle pulse.
REQ-020 err  out  1  one-cycle pulse on a rejected or aborted access.
REQ-021 halted  out  1  sticky; the processor has halted.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, DONE, HALT.
REQ-023 IDLE, memread xor memwrt, addr[0]=0:
- latch addr, wdata and op;
- go to REQ;
- stall=1 combinationally in the same cycle.
REQ-024 IDLE, memread and memwrt both 1, or addr[0]=1:
- err pulse next cycle;
- no mem_en;
- remain in IDLE;
- stall=0.
REQ-025 REQ:
- mem_en=1 with latched op, address and data;
- if mem_busy=1, remain in REQ and re-present the request unchanged;
- else go to WAIT and clear the timeout counter.
REQ-026 WAIT:
- mem_en=0;
- on mem_done, capture mem_rdata into rdata (reads only) and go to DONE;
- else increment the counter;
- at counter==TIMEOUT, pulse err and go to IDLE with rdata unchanged.
REQ-027 DONE:
- stall=0;
- rdata_valid=1 for reads only;
- next state IDLE, or HALT if a dump is pending.
REQ-028 stall=1 in REQ and WAIT, and in IDLE per REQ-023; 0 otherwise, including in HALT.
REQ-029 Minimum load latency: request cycle plus 3 cycles (REQ, WAIT with immediate mem_done, DONE).
REQ-030 dmp in IDLE with no request: mem_dump pulse next cycle; go to HALT.
REQ-031 dmp together with a valid request: the access proceeds; dump is pending; mem_dump is issued on the DONE to HALT transition.
REQ-032 dmp during REQ or WAIT: set dump pending; the access completes first.
REQ-033 Timeout with dump pending: go to HALT instead of IDLE; issue mem_dump.
REQ-034 HALT:
- absorbing until reset;
- halted=1;
- all requests ignored;
- mem_en=0.
REQ-035 mem_done in any state other than WAIT is ignored.
REQ-036 Timeout counter: width clog2(TIMEOUT+1); saturates and never wraps.

Reset
REQ-037 rst_n=0 at a clock edge forces:
- state IDLE;
- all outputs 0;
- rdata 0;
- counter 0;
- dump pending 0.
REQ-038 Reset mid-access abandons the access with no further mem_en; a reset in HALT clears halted.

Structure
REQ-039 Shared package holds:
- the state enumeration;
- the TIMEOUT and AW defaults;
- the op encoding (OP_RD, OP_WR).
REQ-040 One sub-module: dmem_timeout_cnt (clear, enable, saturate, terminal-count flag); everything else is flat in dmem_access_ctrl.

Verification
REQ-041 LD addr=0x0010, mem_busy=0, mem_done one cycle after REQ, mem_rdata=0xBEEF -> stall high for 3 cycles; rdata=0xBEEF; rdata_valid one pulse in DONE.
REQ-042 ST addr=0x0020, wdata=0x1234, mem_busy=1 for 2 cycles -> mem_en held 3 cycles with constant addr/data; mem_wr=1; no rdata_valid.
REQ-043 LD addr=0x0011 -> err pulse; mem_en never asserts; stall=0.
REQ-044 LD with mem_done never asserted, TIMEOUT=15 -> err after 15 WAIT cycles; return to IDLE; stall drops.
REQ-045 dmp asserted during WAIT of a LD -> load completes; then a single mem_dump pulse; halted=1; later requests ignored.
REQ-046 rst_n=0 during WAIT -> next cycle IDLE with all outputs 0; a late mem_done is ignored.
